// File: rtl/bids_n_pkg.sv
// Shared types and reset constants for the bids_n auction controller.
// Encodings are fixed because the host software and the bidErr/err outputs expose them.
package bids_n_pkg;

    typedef enum logic [3:0] {
        NO_OP     = 4'd0,
        UNLOCK    = 4'd1,
        LOCK      = 4'd2,
        LOAD      = 4'd3,
        SETMASK   = 4'd4,
        SETTIMER  = 4'd5,
        SETCHARGE = 4'd6
    } op_t;

    typedef enum logic [2:0] {
        NOERR           = 3'd0,
        BADKEY          = 3'd1,
        ALREADYUNLOCKED = 3'd2,
        CSTARTUNLOCKED  = 3'd3,
        BADOP           = 3'd4,
        LOCKEDOP        = 3'd5,
        BADIDX          = 3'd6
    } ctl_err_t;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        NOFUNDS = 3'd1,
        MASKED  = 3'd2,
        BOTH    = 3'd3,
        ZEROBID = 3'd4
    } bid_err_t;

    typedef enum logic [2:0] {
        ST_UNLOCKED = 3'd0,
        ST_LOCKED   = 3'd1,
        ST_COOLDOWN = 3'd2,
        ST_ROUND    = 3'd3,
        ST_RESOLVE  = 3'd4
    } state_t;

    localparam int RST_COOLDOWN = 15;
    localparam int RST_CHARGE   = 1;

endpackage

// File: rtl/bids_n_if.sv
// Host control and bidder channel bundle for bids_n, plus the FSM state for observation.
interface bids_n_if #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 4,
    parameter int IDXW       = $clog2(NUMBIDDERS)
);
    // Bidder strobes are single-cycle requests with no backpressure: a bid or retract
    // sampled in a ROUND cycle is always consumed, and ack/bidErr report its outcome
    // one cycle later (exactly one of ack=1 or bidErr!=NONE per asserted strobe).
    logic [3:0]                       C_op;
    logic [DATAWIDTH-1:0]             C_data;
    logic [IDXW-1:0]                  C_idx;
    logic                             C_start;
    logic [NUMBIDDERS-1:0]            bid;
    logic [NUMBIDDERS-1:0]            retract;
    logic [NUMBIDDERS*DATAWIDTH-1:0]  bidAmt;
    logic [NUMBIDDERS-1:0]            ack;
    logic [NUMBIDDERS*3-1:0]          bidErr;
    logic [NUMBIDDERS*DATAWIDTH-1:0]  balance;
    logic [NUMBIDDERS-1:0]            win;
    logic                             ready;
    logic [2:0]                       err;
    logic                             roundOver;
    logic [DATAWIDTH-1:0]             maxBid;
    logic [2:0]                       dbg_state;

    modport master (
        output C_op, C_data, C_idx, C_start, bid, retract, bidAmt,
        input  ack, bidErr, balance, win, ready, err, roundOver, maxBid, dbg_state
    );

    modport slave (
        input  C_op, C_data, C_idx, C_start, bid, retract, bidAmt,
        output ack, bidErr, balance, win, ready, err, roundOver, maxBid, dbg_state
    );

endinterface

// File: rtl/bids_n_maxsel.sv
// Combinational argmax over packed values; strict compare keeps the lowest index on ties.
module bids_n_maxsel #(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 4,
    parameter int IDXW       = $clog2(NUMBIDDERS)
) (
    input  logic [NUMBIDDERS*DATAWIDTH-1:0] vals,
    output logic [IDXW-1:0]                 idx,
    output logic [DATAWIDTH-1:0]            value,
    output logic                            valid
);

    always_comb begin
        idx   = '0;
        value = '0;
        for (int i = 0; i < NUMBIDDERS; i++) begin
            if (vals[i*DATAWIDTH +: DATAWIDTH] > value) begin
                value = vals[i*DATAWIDTH +: DATAWIDTH];
                idx   = IDXW'(i);
            end
        end
        valid = (value != '0);
    end

endmodule

// File: rtl/bids_n.sv
// Lockable N-bidder auction controller: host setup while unlocked, bidding rounds while
// locked, single winner resolved and debited at round close.
module bids_n
    import bids_n_pkg::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 4,
    parameter int IDXW       = $clog2(NUMBIDDERS)
) (
    input  logic   clk,
    input  logic   reset,
    bids_n_if.slave bus
);

    state_t                          state;
    logic [DATAWIDTH-1:0]            bal     [NUMBIDDERS];
    logic [DATAWIDTH-1:0]            lastbid [NUMBIDDERS];
    logic [NUMBIDDERS-1:0]           mask;
    logic [DATAWIDTH-1:0]            charge;
    logic [DATAWIDTH-1:0]            cooldown;
    logic [DATAWIDTH-1:0]            key;
    logic [DATAWIDTH-1:0]            cnt;
    logic [IDXW-1:0]                 win_idx;
    logic                            win_valid;

    logic [NUMBIDDERS-1:0]           ack_q;
    logic [NUMBIDDERS*3-1:0]         bid_err_q;
    logic [NUMBIDDERS-1:0]           win_q;
    logic                            ready_q;
    ctl_err_t                        err_q;
    logic                            round_over_q;
    logic [DATAWIDTH-1:0]            max_bid_q;

    logic [DATAWIDTH-1:0]            bal_nxt [NUMBIDDERS];
    logic [DATAWIDTH-1:0]            lb_nxt  [NUMBIDDERS];
    logic [NUMBIDDERS-1:0]           ack_nxt;
    logic [NUMBIDDERS*3-1:0]         berr_nxt;
    logic [NUMBIDDERS*DATAWIDTH-1:0] lb_flat;
    logic [NUMBIDDERS*DATAWIDTH-1:0] bal_flat;
    logic [IDXW-1:0]                 sel_idx;
    logic [DATAWIDTH-1:0]            sel_val;
    logic                            sel_valid;

    // Per-bidder round outcome; the funds check is one bit wider so a huge bid cannot wrap.
    always_comb begin
        ack_nxt  = '0;
        berr_nxt = '0;
        for (int i = 0; i < NUMBIDDERS; i++) begin
            bal_nxt[i] = bal[i];
            lb_nxt[i]  = lastbid[i];
            if (bus.bid[i] || bus.retract[i]) begin
                if (!mask[i]) begin
                    berr_nxt[i*3 +: 3] = MASKED;
                end else if (bus.bid[i] && bus.retract[i]) begin
                    berr_nxt[i*3 +: 3] = BOTH;
                end else if (bus.bid[i]) begin
                    if (({1'b0, bus.bidAmt[i*DATAWIDTH +: DATAWIDTH]} + {1'b0, charge})
                            > {1'b0, bal[i]}) begin
                        berr_nxt[i*3 +: 3] = NOFUNDS;
                    end else if (bus.bidAmt[i*DATAWIDTH +: DATAWIDTH] == '0) begin
                        berr_nxt[i*3 +: 3] = ZEROBID;
                    end else begin
                        bal_nxt[i] = bal[i] - charge;
                        lb_nxt[i]  = bus.bidAmt[i*DATAWIDTH +: DATAWIDTH];
                        ack_nxt[i] = 1'b1;
                    end
                end else begin
                    lb_nxt[i]  = '0;
                    ack_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUMBIDDERS; i++) begin
            lb_flat[i*DATAWIDTH +: DATAWIDTH]  = lb_nxt[i];
            bal_flat[i*DATAWIDTH +: DATAWIDTH] = bal[i];
        end
    end

    // Winner is picked from the post-update bids so the final ROUND cycle counts.
    bids_n_maxsel #(
        .DATAWIDTH (DATAWIDTH),
        .NUMBIDDERS(NUMBIDDERS),
        .IDXW      (IDXW)
    ) u_maxsel (
        .vals (lb_flat),
        .idx  (sel_idx),
        .value(sel_val),
        .valid(sel_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_UNLOCKED;
            for (int i = 0; i < NUMBIDDERS; i++) begin
                bal[i]     <= '0;
                lastbid[i] <= '0;
            end
            mask         <= '1;
            charge       <= DATAWIDTH'(RST_CHARGE);
            cooldown     <= DATAWIDTH'(RST_COOLDOWN);
            key          <= '0;
            cnt          <= '0;
            win_idx      <= '0;
            win_valid    <= 1'b0;
            ack_q        <= '0;
            bid_err_q    <= '0;
            win_q        <= '0;
            ready_q      <= 1'b0;
            err_q        <= NOERR;
            round_over_q <= 1'b0;
            max_bid_q    <= '0;
        end else begin
            ack_q        <= '0;
            bid_err_q    <= '0;
            win_q        <= '0;
            ready_q      <= 1'b0;
            err_q        <= NOERR;
            round_over_q <= 1'b0;
            max_bid_q    <= '0;
            case (state)
                ST_UNLOCKED: begin
                    if (bus.C_start) begin
                        err_q <= CSTARTUNLOCKED;
                    end else begin
                        case (bus.C_op)
                            NO_OP:     ;
                            LOAD: begin
                                if (int'(bus.C_idx) >= NUMBIDDERS) err_q <= BADIDX;
                                else bal[bus.C_idx] <= bus.C_data;
                            end
                            SETMASK:   mask     <= bus.C_data[NUMBIDDERS-1:0];
                            SETTIMER:  cooldown <= bus.C_data;
                            SETCHARGE: charge   <= bus.C_data;
                            LOCK: begin
                                key     <= bus.C_data;
                                state   <= ST_LOCKED;
                                ready_q <= 1'b1;
                            end
                            UNLOCK:    err_q <= ALREADYUNLOCKED;
                            default:   err_q <= BADOP;
                        endcase
                    end
                end
                ST_LOCKED: begin
                    ready_q <= 1'b1;
                    if (bus.C_op == UNLOCK) begin
                        ready_q <= 1'b0;
                        if (bus.C_data == key) begin
                            state <= ST_UNLOCKED;
                        end else begin
                            state <= ST_COOLDOWN;
                            cnt   <= cooldown;
                            err_q <= BADKEY;
                        end
                    end else begin
                        if (bus.C_op != NO_OP) err_q <= LOCKEDOP;
                        if (bus.C_start) begin
                            state   <= ST_ROUND;
                            ready_q <= 1'b0;
                            for (int i = 0; i < NUMBIDDERS; i++) lastbid[i] <= '0;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    // err stays BADKEY for exactly the cycles spent here.
                    if (cnt == '0) begin
                        state   <= ST_LOCKED;
                        ready_q <= 1'b1;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        err_q <= BADKEY;
                    end
                end
                ST_ROUND: begin
                    for (int i = 0; i < NUMBIDDERS; i++) begin
                        bal[i]     <= bal_nxt[i];
                        lastbid[i] <= lb_nxt[i];
                    end
                    ack_q     <= ack_nxt;
                    bid_err_q <= berr_nxt;
                    if (bus.C_op != NO_OP) err_q <= LOCKEDOP;
                    if (!bus.C_start) begin
                        state        <= ST_RESOLVE;
                        round_over_q <= 1'b1;
                        max_bid_q    <= sel_val;
                        win_q        <= sel_valid ? (NUMBIDDERS'(1) << sel_idx) : '0;
                        win_idx      <= sel_idx;
                        win_valid    <= sel_valid;
                    end
                end
                ST_RESOLVE: begin
                    if (win_valid) bal[win_idx] <= bal[win_idx] - lastbid[win_idx];
                    if (bus.C_op != NO_OP) err_q <= LOCKEDOP;
                    state   <= ST_LOCKED;
                    ready_q <= 1'b1;
                end
                default: state <= ST_UNLOCKED;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.bidErr    = bid_err_q;
    assign bus.balance   = bal_flat;
    assign bus.win       = win_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.roundOver = round_over_q;
    assign bus.maxBid    = max_bid_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bids_n.sv
// Scenario bench for bids_n with 5 bidders (non power of two) and a round-result scoreboard.
module tb_bids_n;
    import bids_n_pkg::*;

    localparam int NB = 5;
    localparam int DW = 32;
    localparam int IW = 3;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [NB+DW-1:0] exp_q[$];
    logic [NB+DW-1:0] exp_v;

    bids_n_if #(.DATAWIDTH(DW), .NUMBIDDERS(NB), .IDXW(IW)) bus ();

    bids_n #(.DATAWIDTH(DW), .NUMBIDDERS(NB), .IDXW(IW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bal_of(input int i);
        return bus.balance[i*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.C_op    = NO_OP;
        bus.C_data  = '0;
        bus.C_idx   = '0;
        bus.C_start = 1'b0;
        bus.bid     = '0;
        bus.retract = '0;
        bus.bidAmt  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic host_op(input logic [3:0] op, input logic [DW-1:0] data, input logic [IW-1:0] idx);
        bus.C_op   = op;
        bus.C_data = data;
        bus.C_idx  = idx;
        step();
        bus.C_op   = NO_OP;
        bus.C_data = '0;
        bus.C_idx  = '0;
    endtask

    task automatic set_bid(input int i, input logic [DW-1:0] amt);
        bus.bid[i] = 1'b1;
        bus.bidAmt[i*DW +: DW] = amt;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus.dbg_state !== 3'(ST_UNLOCKED)) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
        n_tests++; if (bus.balance !== '0) begin n_fail++; $display("FAIL reset_balance: got %0h want 0", bus.balance); end
        n_tests++; if ({bus.ack, bus.bidErr, bus.win, bus.ready, bus.err, bus.roundOver, bus.maxBid} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: ack=%b bidErr=%b win=%b ready=%b err=%0d ro=%b maxBid=%0d",
                bus.ack, bus.bidErr, bus.win, bus.ready, bus.err, bus.roundOver, bus.maxBid); end
    endtask

    task automatic test_basic_round();
        do_reset();
        host_op(LOAD, 100, 0);
        host_op(LOAD, 50, 1);
        host_op(LOCK, 32'hA5, 0);
        n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", bus.ready); end
        bus.C_start = 1'b1;
        step();
        set_bid(0, 30);
        set_bid(1, 40);
        bus.C_start = 1'b0;
        exp_q.push_back({5'b00010, 32'd40});
        step();
        clear_inputs();
        n_tests++; if (bus.ack !== 5'b00011) begin n_fail++; $display("FAIL basic_ack: got %b want 00011", bus.ack); end
        n_tests++;
        if (bus.roundOver !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL basic_roundover: got %b want 1", bus.roundOver);
        end else begin
            exp_v = exp_q.pop_front();
            if ({bus.win, bus.maxBid} !== exp_v) begin n_fail++; $display("FAIL basic_result: got %h want %h", {bus.win, bus.maxBid}, exp_v); end
        end
        step();
        n_tests++; if (bal_of(0) !== 32'd99) begin n_fail++; $display("FAIL basic_bal0: got %0d want 99", bal_of(0)); end
        n_tests++; if (bal_of(1) !== 32'd9) begin n_fail++; $display("FAIL basic_bal1: got %0d want 9", bal_of(1)); end
        n_tests++; if (bus.ready !== 1'b1 || bus.roundOver !== 1'b0) begin n_fail++; $display("FAIL basic_after: ready=%b ro=%b want 1 0", bus.ready, bus.roundOver); end
    endtask

    task automatic test_cooldown();
        int cyc;
        do_reset();
        host_op(SETTIMER, 3, 0);
        host_op(LOCK, 7, 0);
        host_op(UNLOCK, 8, 0);
        cyc = 0;
        while (bus.err === 3'(BADKEY) && cyc < 40) begin
            cyc++;
            host_op(LOAD, 1, 0);
        end
        n_tests++; if (cyc != 4) begin n_fail++; $display("FAIL cooldown_len: got %0d want 4", cyc); end
        n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL cooldown_ready: got %b want 1", bus.ready); end
        n_tests++; if (bal_of(0) !== 32'd0) begin n_fail++; $display("FAIL cooldown_ignored_op: got %0d want 0", bal_of(0)); end
        host_op(UNLOCK, 7, 0);
        n_tests++; if (bus.dbg_state !== 3'(ST_UNLOCKED) || bus.err !== 3'(NOERR)) begin
            n_fail++; $display("FAIL cooldown_unlock: state=%0d err=%0d want 0 0", bus.dbg_state, bus.err); end
    endtask

    task automatic test_funds();
        do_reset();
        host_op(LOAD, 10, 0);
        host_op(LOCK, 1, 0);
        bus.C_start = 1'b1;
        step();
        set_bid(0, 10);
        step();
        n_tests++; if (bus.bidErr[2:0] !== 3'(NOFUNDS) || bus.ack[0] !== 1'b0) begin
            n_fail++; $display("FAIL funds_exact: bidErr=%0d ack=%b want 1 0", bus.bidErr[2:0], bus.ack[0]); end
        set_bid(0, 32'hFFFF_FFFF);
        step();
        n_tests++; if (bus.bidErr[2:0] !== 3'(NOFUNDS)) begin n_fail++; $display("FAIL funds_wrap: got %0d want 1", bus.bidErr[2:0]); end
        set_bid(0, 0);
        step();
        n_tests++; if (bus.bidErr[2:0] !== 3'(ZEROBID)) begin n_fail++; $display("FAIL funds_zero: got %0d want 4", bus.bidErr[2:0]); end
        set_bid(0, 9);
        step();
        bus.bid = '0;
        n_tests++; if (bus.ack !== 5'b00001 || bal_of(0) !== 32'd9) begin
            n_fail++; $display("FAIL funds_accept: ack=%b bal=%0d want 00001 9", bus.ack, bal_of(0)); end
        bus.C_start = 1'b0;
        exp_q.push_back({5'b00001, 32'd9});
        step();
        n_tests++;
        if (bus.roundOver !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL funds_roundover: got %b want 1", bus.roundOver);
        end else begin
            exp_v = exp_q.pop_front();
            if ({bus.win, bus.maxBid} !== exp_v) begin n_fail++; $display("FAIL funds_result: got %h want %h", {bus.win, bus.maxBid}, exp_v); end
        end
        step();
        n_tests++; if (bal_of(0) !== 32'd0) begin n_fail++; $display("FAIL funds_debit: got %0d want 0", bal_of(0)); end
    endtask

    task automatic test_tie_break();
        do_reset();
        host_op(LOAD, 100, 2);
        host_op(LOAD, 100, 3);
        host_op(LOCK, 3, 0);
        bus.C_start = 1'b1;
        step();
        set_bid(2, 20);
        set_bid(3, 20);
        step();
        bus.bid = '0;
        n_tests++; if (bus.ack !== 5'b01100) begin n_fail++; $display("FAIL tie_ack: got %b want 01100", bus.ack); end
        bus.retract[2] = 1'b1;
        step();
        bus.retract = '0;
        n_tests++; if (bus.ack !== 5'b00100) begin n_fail++; $display("FAIL tie_retract_ack: got %b want 00100", bus.ack); end
        bus.C_start = 1'b0;
        exp_q.push_back({5'b01000, 32'd20});
        step();
        n_tests++;
        if (bus.roundOver !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL tie_retract_roundover: got %b want 1", bus.roundOver);
        end else begin
            exp_v = exp_q.pop_front();
            if ({bus.win, bus.maxBid} !== exp_v) begin n_fail++; $display("FAIL tie_retract_result: got %h want %h", {bus.win, bus.maxBid}, exp_v); end
        end
        step();
        bus.C_start = 1'b1;
        step();
        set_bid(2, 20);
        set_bid(3, 20);
        bus.C_start = 1'b0;
        exp_q.push_back({5'b00100, 32'd20});
        step();
        clear_inputs();
        n_tests++;
        if (bus.roundOver !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL tie_low_roundover: got %b want 1", bus.roundOver);
        end else begin
            exp_v = exp_q.pop_front();
            if ({bus.win, bus.maxBid} !== exp_v) begin n_fail++; $display("FAIL tie_low_result: got %h want %h", {bus.win, bus.maxBid}, exp_v); end
        end
        step();
        n_tests++; if (bal_of(2) !== 32'd78 || bal_of(3) !== 32'd78) begin
            n_fail++; $display("FAIL tie_balances: got %0d %0d want 78 78", bal_of(2), bal_of(3)); end
    endtask

    task automatic test_mask_both();
        do_reset();
        host_op(LOAD, 50, 0);
        host_op(LOAD, 50, 1);
        host_op(SETMASK, 32'b11110, 0);
        host_op(LOCK, 9, 0);
        bus.C_start = 1'b1;
        step();
        set_bid(0, 5);
        set_bid(1, 5);
        bus.retract[1] = 1'b1;
        step();
        clear_inputs();
        bus.C_start = 1'b1;
        n_tests++; if (bus.bidErr[2:0] !== 3'(MASKED)) begin n_fail++; $display("FAIL mask_err: got %0d want 2", bus.bidErr[2:0]); end
        n_tests++; if (bus.bidErr[5:3] !== 3'(BOTH) || bus.ack !== 5'b0) begin
            n_fail++; $display("FAIL both_err: got %0d ack=%b want 3 00000", bus.bidErr[5:3], bus.ack); end
        n_tests++; if (bal_of(0) !== 32'd50 || bal_of(1) !== 32'd50) begin
            n_fail++; $display("FAIL mask_bal: got %0d %0d want 50 50", bal_of(0), bal_of(1)); end
        bus.C_start = 1'b0;
        exp_q.push_back('0);
        step();
        n_tests++;
        if (bus.roundOver !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL mask_roundover: got %b want 1", bus.roundOver);
        end else begin
            exp_v = exp_q.pop_front();
            if ({bus.win, bus.maxBid} !== exp_v) begin n_fail++; $display("FAIL mask_result: got %h want %h", {bus.win, bus.maxBid}, exp_v); end
        end
        step();
    endtask

    task automatic test_host_errors();
        do_reset();
        bus.C_start = 1'b1;
        step();
        bus.C_start = 1'b0;
        n_tests++; if (bus.err !== 3'(CSTARTUNLOCKED) || bus.dbg_state !== 3'(ST_UNLOCKED)) begin
            n_fail++; $display("FAIL err_cstart: err=%0d state=%0d want 3 0", bus.err, bus.dbg_state); end
        host_op(UNLOCK, 0, 0);
        n_tests++; if (bus.err !== 3'(ALREADYUNLOCKED)) begin n_fail++; $display("FAIL err_unlock: got %0d want 2", bus.err); end
        host_op(4'hF, 0, 0);
        n_tests++; if (bus.err !== 3'(BADOP)) begin n_fail++; $display("FAIL err_badop: got %0d want 4", bus.err); end
        host_op(LOAD, 77, 3'd5);
        n_tests++; if (bus.err !== 3'(BADIDX) || bus.balance !== '0) begin
            n_fail++; $display("FAIL err_badidx: err=%0d bal=%0h want 6 0", bus.err, bus.balance); end
        host_op(LOCK, 2, 0);
        host_op(SETMASK, 0, 0);
        n_tests++; if (bus.err !== 3'(LOCKEDOP) || bus.ready !== 1'b1) begin
            n_fail++; $display("FAIL err_lockedop: err=%0d ready=%b want 5 1", bus.err, bus.ready); end
    endtask

    task automatic test_reset_mid_round();
        do_reset();
        host_op(LOAD, 40, 0);
        host_op(LOAD, $urandom_range(10, 1000), 4);
        host_op(LOCK, 1, 0);
        bus.C_start = 1'b1;
        step();
        set_bid(0, 5);
        step();
        n_tests++; if (bus.ack !== 5'b00001) begin n_fail++; $display("FAIL midrst_ack: got %b want 00001", bus.ack); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        n_tests++; if (bus.dbg_state !== 3'(ST_UNLOCKED) || bus.balance !== '0) begin
            n_fail++; $display("FAIL midrst_state: state=%0d bal=%0h want 0 0", bus.dbg_state, bus.balance); end
        n_tests++; if ({bus.ack, bus.bidErr, bus.win, bus.ready, bus.err, bus.roundOver, bus.maxBid} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: ack=%b win=%b ready=%b err=%0d ro=%b", bus.ack, bus.win, bus.ready, bus.err, bus.roundOver); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        clear_inputs();
        test_reset();
        test_basic_round();
        test_cooldown();
        test_funds();
        test_tie_break();
        test_mask_both();
        test_host_errors();
        test_reset_mid_round();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bids_n.md
Name: bids_n

Overview:
- Next-generation auction controller: N parametrised bidder channels arbitrated under a lockable host control port.
- Host loads balances, mask, bid charge and cooldown while unlocked, then locks with a key and runs bidding rounds.
- Each round takes one bid or retract per bidder per cycle. At round close the block resolves a single winner and debits that winner.
- Adds over the 3-bidder controller: indexed load, per-bidder round statistics, tie-break rule, key-protected unlock with cooldown.

Parameters:
- DATAWIDTH, 32, width of balances, bids, key, charge and timer.
- NUMBIDDERS, 4, number of bidder channels (2..16).
- IDXW, $clog2(NUMBIDDERS), width of bidder index fields.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- C_op  in  4  host opcode (op_t)
- C_data  in  DATAWIDTH  host operand
- C_idx  in  IDXW  target bidder for LOAD
- C_start  in  1  round active while high
- bid  in  NUMBIDDERS  per-bidder bid strobe
- retract  in  NUMBIDDERS  per-bidder retract strobe
- bidAmt  in  NUMBIDDERS*DATAWIDTH  packed bid amounts, bidder i at [i*DATAWIDTH +: DATAWIDTH]
- ack  out  NUMBIDDERS  bid or retract accepted (registered)
- bidErr  out  NUMBIDDERS*3  per-bidder bid_err_t (registered)
- balance  out  NUMBIDDERS*DATAWIDTH  current balances
- win  out  NUMBIDDERS  one-hot winner pulse
- ready  out  1  locked and idle
- err  out  3  host ctl_err_t
- roundOver  out  1  one-cycle round-close pulse
- maxBid  out  DATAWIDTH  winning amount, valid with roundOver

Behaviour:
- Reset (synchronous, reset=1 at posedge clk), including mid-round:
  - state=UNLOCKED; all balances and lastbids 0; mask all-ones; bidcharge=1; cooldown=15; key=0.
  - All outputs 0, err=NOERR.
- States: UNLOCKED, LOCKED, COOLDOWN, ROUND, RESOLVE.
- UNLOCKED, ops take effect next cycle:
  - LOAD: balance[C_idx] <= C_data. C_idx >= NUMBIDDERS gives err=BADIDX, no write.
  - SETMASK, SETTIMER, SETCHARGE: write the register.
  - LOCK: key <= C_data, go to LOCKED.
  - UNLOCK gives err=ALREADYUNLOCKED.
  - C_start=1 gives err=CSTARTUNLOCKED.
  - Undefined op gives err=BADOP.
- LOCKED:
  - ready=1.
  - UNLOCK with C_data==key goes to UNLOCKED.
  - UNLOCK with any other key goes to COOLDOWN with counter loaded from cooldown.
  - C_start=1 goes to ROUND and clears all lastbids.
  - Any other non-NO_OP op gives err=LOCKEDOP.
- COOLDOWN:
  - err=BADKEY every cycle; counter decrements.
  - At counter==0, go to LOCKED next cycle. Stay time is cooldown+1 cycles; cooldown=0 gives 1 cycle.
  - All ops are ignored.
- ROUND, per bidder i each cycle:
  - mask[i]=0 and bid or retract asserted: bidErr=MASKED, no change.
  - bid and retract both asserted: bidErr=BOTH, no change.
  - bid with bidAmt+charge > balance (DATAWIDTH+1-bit compare, no wrap): bidErr=NOFUNDS.
  - bid with bidAmt==0: bidErr=ZEROBID.
  - Otherwise the bid is accepted: balance -= charge; lastbid[i] = bidAmt; ack[i]=1.
  - Retract: lastbid[i]=0, no refund, ack[i]=1.
  - ack and bidErr are registered, appearing 1 cycle after the strobe.
  - C_start falling goes to RESOLVE. Bids in that cycle are still processed.
- RESOLVE (1 cycle):
  - Winner = max lastbid; ties go to the lowest index.
  - If any lastbid is nonzero: win[winner]=1, maxBid=lastbid, balance[winner] -= lastbid. Underflow is impossible because bid acceptance guarantees funds.
  - If all lastbids are zero: win=0, maxBid=0.
  - roundOver=1 this cycle, then go to LOCKED.
- Arithmetic is unsigned DATAWIDTH; the charge debit never goes below 0 because of the acceptance check.
- Simultaneous events:
  - Host ops during ROUND or RESOLVE give err=LOCKEDOP and are ignored.
  - reset has priority over everything.

Decomposition:
- bids_n_pkg holds:
  - op_t: NO_OP, UNLOCK, LOCK, LOAD, SETMASK, SETTIMER, SETCHARGE.
  - ctl_err_t: NOERR, BADKEY, ALREADYUNLOCKED, CSTARTUNLOCKED, BADOP, LOCKEDOP, BADIDX.
  - bid_err_t: NONE, NOFUNDS, MASKED, BOTH, ZEROBID.
  - Reset constants: cooldown=15, charge=1.
- Sub-module bids_n_maxsel: combinational NUMBIDDERS-way argmax with lowest-index tie-break, returning index, value and valid. Instantiated once.

Test Plan:
- LOAD idx0=100 and idx1=50, LOCK key=0xA5, C_start; bidder0 bids 30, bidder1 bids 40, C_start low -> ack both.
  - RESOLVE: win=0b0010, maxBid=40, roundOver=1.
  - Final balances: bidder0=99, bidder1=9.
- SETTIMER=3, LOCK key=7, UNLOCK data=8 -> err=BADKEY for exactly 4 cycles, then ready=1. UNLOCK data=7 -> UNLOCKED.
- Balance 10, charge 1, bid 10 -> bidErr=NOFUNDS. Bid 9 -> ack, balance 9.
- Two bidders both bid 20 -> win goes to the lower index. Retract that one in the next cycle -> the other wins, maxBid=20.
- SETMASK=0b1110; bidder0 bids -> bidErr=MASKED. Bid and retract together on bidder1 -> bidErr=BOTH.
- reset asserted mid-ROUND -> next cycle state=UNLOCKED, balances 0, outputs 0. LOAD with C_idx=NUMBIDDERS (when not a power of 2) -> err=BADIDX.
